// File: rtl/osc_tick_arbiter_if.sv
// osc_tick_arbiter_if: requester-side bundle for osc_tick_arbiter.
// ABORTED/ABORT_STICKY exist only when OSC_TICK_ARB_ABORT_EN is defined.
interface osc_tick_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 16
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*CNT_W-1:0] dly;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic busy;
  logic tick;
`ifdef OSC_TICK_ARB_ABORT_EN
  logic [NUM_REQ-1:0] aborted;
  logic abort_sticky;
  modport master(output req, dly, input gnt, done, busy, tick, aborted, abort_sticky);
  modport slave(input req, dly, output gnt, done, busy, tick, aborted, abort_sticky);
`else
  modport master(output req, dly, input gnt, done, busy, tick);
  modport slave(input req, dly, output gnt, done, busy, tick);
`endif
endinterface

// File: rtl/osc_tick_arbiter.sv
// osc_tick_arbiter: round-robin shared prescaled delay timer running on the oscillator clock.
// Define OSC_TICK_ARB_ABORT_EN to add ABORTED pulses and the ABORT_STICKY flag.
module osc_tick_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 16,
  parameter int PRESCALE = 10
) (
  input logic clk_i,
  input logic rst_ni,
  osc_tick_arbiter_if.slave bus
);
  localparam int SW = $clog2(NUM_REQ);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;
  state_e state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, last_q, last_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d, dly_sel;
  logic [PW-1:0] pre_q, pre_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic busy_q, busy_d, tick_q, tick_d, abort, wrap, found;
  assign dly_sel = bus.dly[sel_q*CNT_W +: CNT_W];
  assign wrap = pre_q == PMAX;
  assign abort = (state_q == S_LOAD || state_q == S_RUN) && !bus.req[sel_q];
  // Search starts just after the last granted requester, so it becomes lowest priority
  always_comb begin
    pick = last_q;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && bus.req[SW'((int'(last_q) + i) % NUM_REQ)]) begin
        found = 1'b1;
        pick = SW'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    last_d = last_q;
    cnt_d = cnt_q;
    pre_d = pre_q;
    case (state_q)
      S_IDLE: begin
        sel_d = |bus.req ? pick : sel_q;
        state_d = |bus.req ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        last_d = sel_q;
        cnt_d = dly_sel;
        pre_d = '0;
        state_d = abort ? S_IDLE : (dly_sel == '0 ? S_DONE : S_RUN);
      end
      S_RUN: begin
        pre_d = wrap ? '0 : pre_q + 1'b1;
        cnt_d = wrap ? cnt_q - 1'b1 : cnt_q;
        state_d = abort ? S_IDLE : (wrap && cnt_q == CNT_W'(1) ? S_DONE : S_RUN);
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from next state so they leave the block registered
    busy_d = state_d != S_IDLE;
    gnt_d = busy_d ? NUM_REQ'(1) << sel_d : '0;
    done_d = state_d == S_DONE ? NUM_REQ'(1) << sel_d : '0;
    tick_d = state_d == S_RUN && pre_d == PMAX;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sel_q <= '0;
      last_q <= SW'(NUM_REQ - 1);
      cnt_q <= '0;
      pre_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      busy_q <= busy_d;
      tick_q <= tick_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.tick = tick_q;
`ifdef OSC_TICK_ARB_ABORT_EN
  logic [NUM_REQ-1:0] aborted_q;
  logic sticky_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aborted_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      aborted_q <= abort ? NUM_REQ'(1) << sel_q : '0;
      sticky_q <= sticky_q | abort;
    end
  end
  assign bus.aborted = aborted_q;
  assign bus.abort_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_osc_tick_arbiter.sv
// tb_osc_tick_arbiter: two arbiters (PRESCALE 10 and 1) on shared requests, checked
// every cycle against a cycle-number transaction model.
module tb_osc_tick_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] dly = '0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int ps[2] = '{10, 1};
  bit m_busy[2];
  bit m_ab[2];
  bit m_sticky[2];
  int m_g[2];
  int m_t0[2];
  int m_end[2];
  int m_last[2];
  osc_tick_arbiter_if #(.NUM_REQ(N), .CNT_W(W)) ifa ();
  osc_tick_arbiter_if #(.NUM_REQ(N), .CNT_W(W)) ifb ();
  assign ifa.req = req;
  assign ifa.dly = dly;
  assign ifb.req = req;
  assign ifb.dly = dly;
  osc_tick_arbiter #(.NUM_REQ(N), .CNT_W(W), .PRESCALE(10)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
  osc_tick_arbiter #(.NUM_REQ(N), .CNT_W(W), .PRESCALE(1)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));
  always #5 clk = ~clk;

  function automatic int rr_pick(int last, logic [N-1:0] r);
    for (int i = 1; i <= N; i++) if (r[(last + i) % N]) return (last + i) % N;
    return 0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_ab[k] = 1'b0;
      m_sticky[k] = 1'b0;
      m_g[k] = 0;
      m_last[k] = N - 1;
    end
  endtask

  // Advance the model across the edge that ends cycle cyc, using the inputs seen at that edge
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_ab[k] = 1'b0;
      if (!rst_n) begin
        m_busy[k] = 1'b0;
        m_sticky[k] = 1'b0;
        m_last[k] = N - 1;
      end else if (!m_busy[k]) begin
        if (|req) begin
          m_g[k] = rr_pick(m_last[k], req);
          m_busy[k] = 1'b1;
          m_t0[k] = cyc + 1;
          m_end[k] = -1;
        end
      end else if (cyc == m_end[k]) begin
        m_busy[k] = 1'b0;
      end else begin
        if (cyc == m_t0[k]) begin
          m_last[k] = m_g[k];
          if (req[m_g[k]]) m_end[k] = m_t0[k] + 1 + int'(dly[m_g[k]*W +: W]) * ps[k];
        end
        if (!req[m_g[k]]) begin
          m_busy[k] = 1'b0;
          m_ab[k] = 1'b1;
          m_sticky[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check();
    logic [N-1:0] eg, ed;
    logic et;
    for (int k = 0; k < 2; k++) begin
      eg = m_busy[k] ? N'(1) << m_g[k] : '0;
      ed = (m_busy[k] && cyc == m_end[k]) ? eg : '0;
      et = m_busy[k] && m_end[k] >= 0 && cyc > m_t0[k] && cyc < m_end[k] && (cyc - m_t0[k]) % ps[k] == 0;
      chk($sformatf("gnt%0d", k), k ? ifb.gnt : ifa.gnt, eg);
      chk($sformatf("done%0d", k), k ? ifb.done : ifa.done, ed);
      chk($sformatf("busy%0d", k), k ? ifb.busy : ifa.busy, m_busy[k]);
      chk($sformatf("tick%0d", k), k ? ifb.tick : ifa.tick, et);
`ifdef OSC_TICK_ARB_ABORT_EN
      chk($sformatf("aborted%0d", k), k ? ifb.aborted : ifa.aborted, m_ab[k] ? N'(1) << m_g[k] : '0);
      chk($sformatf("sticky%0d", k), k ? ifb.abort_sticky : ifa.abort_sticky, m_sticky[k]);
`endif
    end
  endtask

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check();
    end
  endtask

  initial begin
    m_reset();
    #1 rst_n = 1'b0;
    step(3);
    #2 rst_n = 1'b1;
    step(2);
    // single request, delay 3
    dly[0 +: W] = 16'd3;
    req = 4'b0001;
    step(32);
    req = 4'b0000;
    step(3);
    // all requesting with zero delay: rotation and one-hot grants
    dly = '0;
    req = 4'b1111;
    step(16);
    req = 4'b0000;
    step(3);
    // delay 5 on requester 2
    dly[2*W +: W] = 16'd5;
    req = 4'b0100;
    step(55);
    req = 4'b0000;
    step(3);
    // long delay dropped mid-run
    dly[0 +: W] = 16'd100;
    req = 4'b0001;
    step(50);
    req = 4'b0000;
    step(3);
    // asynchronous reset during RUN with another requester pending
    dly[0 +: W] = 16'd50;
    dly[W +: W] = 16'd50;
    req = 4'b0011;
    step(20);
    #3 rst_n = 1'b0;
    #1 m_reset();
    check();
    step(2);
    #2 rst_n = 1'b1;
    dly[W +: W] = 16'd2;
    req = 4'b0010;
    step(23);
    req = 4'b0000;
    step(3);
    // delay changed while running only affects the next load
    dly[W +: W] = 16'd4;
    req = 4'b0010;
    step(10);
    dly[W +: W] = 16'd1;
    step(45);
    req = 4'b0000;
    step(3);
    // randomized requests, drops and delays
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(7) == 0) req[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(3) == 0) dly[$urandom_range(N - 1)*W +: W] = 16'($urandom_range(4));
      step();
    end
    req = 4'b0000;
    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/osc_tick_arbiter.md
Name: osc_tick_arbiter

Overview:
- Shares a single prescaled timer between NUM_REQ requesters. The timer is clocked from the on-chip oscillator output, e.g. 2.5 MHz nominal.
- Each requester asks for a delay of DLY ticks. The block grants requesters round-robin, counts the delay, then pulses that requester's DONE.
- Sits next to the oscillator primitive. It serves power-up sequencing, flash-wait and watchdog-style delays that must not depend on the system PLL.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..8.
- CNT_W, 16: width of each delay request, in ticks.
- PRESCALE, 10: oscillator cycles per tick, range 1..65535.

Ports:
- CLK  in  1: oscillator clock; all logic is on its rising edge.
- RSTN  in  1: asynchronous, active-low reset.
- REQ  in  NUM_REQ: level request per requester; held until DONE or abort.
- DLY  in  NUM_REQ*CNT_W: delay per requester; slice i is DLY[i*CNT_W +: CNT_W]; sampled only at LOAD.
- GNT  out  NUM_REQ: one-hot; high for the granted requester from LOAD through DONE.
- DONE  out  NUM_REQ: one-cycle completion pulse for the granted requester.
- BUSY  out  1: high in any state other than IDLE.
- TICK  out  1: one-cycle pulse per prescaler wrap; only in RUN.

Behaviour:
- Reset (RSTN low, asynchronous):
  - GNT=0, DONE=0, BUSY=0, TICK=0.
  - State=IDLE, prescaler=0, count=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-operation discards the request silently: no DONE is issued.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any REQ is high, select the first set bit searching last+1, last+2, ... with wrap modulo NUM_REQ. Register the selection as sel and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - GNT[sel]=1, BUSY=1.
  - count <= DLY slice sel; prescaler <= 0; last <= sel.
  - If the slice is 0, go to DONE; otherwise go to RUN.
- RUN:
  - prescaler increments each cycle. At PRESCALE-1 it wraps to 0, TICK=1 and count decrements.
  - When count==1 and a tick occurs, go to DONE.
  - With PRESCALE=1, TICK fires every RUN cycle.
- DONE (1 cycle):
  - DONE[sel]=1, GNT[sel] stays 1.
  - Next state is IDLE; GNT drops in that cycle.
- Latency: REQ sampled in IDLE at cycle 0 gives DONE pulse at cycle 2 + D*PRESCALE, where D is the loaded delay.
  - Example: D=0 gives DONE at cycle 2.
  - Back-to-back: the next grant's LOAD is no earlier than 2 cycles after DONE (DONE, IDLE, LOAD).
- Abort: if REQ[sel] is low in LOAD or RUN, go to IDLE next cycle.
  - GNT clears and no DONE is issued; last is already sel, so the pointer has advanced.
  - REQ[sel] dropping in the DONE cycle is ignored; DONE still pulses.
- Requests from non-granted requesters are held pending and are never lost. REQ changes during service affect only abort.
- If the granted requester still has REQ high after its DONE, it is re-arbitrated at lowest priority.
- Count and prescaler never wrap below 0. A count of 0 exists only in LOAD, which goes straight to DONE.
- All outputs are registered and glitch-free; there is no combinational path from REQ to any output.

Optional Feature:
- Macro: OSC_TICK_ARB_ABORT_EN.
- Defined:
  - Adds output ABORTED [NUM_REQ-1:0], reset 0.
  - ABORTED[sel] pulses for one cycle in the cycle the FSM returns to IDLE on an abort.
  - Adds output ABORT_STICKY (1 bit), set on any abort and cleared only by RSTN.
- Undefined: neither port exists and aborts are silent. All other behaviour is identical.

Test Plan:
- Default parameters, REQ=4'b0001, DLY0=3 at cycle 0 -> GNT=0001 from cycle 1; TICK at cycles 11, 21, 31; DONE=0001 at cycle 32; BUSY low at cycle 33.
- REQ=4'b1111 held, all DLY=0 -> DONE order 0,1,2,3,0, spaced 3 cycles apart; GNT always one-hot.
- PRESCALE=1, DLY2=5, REQ=0100 -> TICK on 5 consecutive cycles; DONE=0100 at cycle 7.
- REQ0 with DLY0=100 dropped at cycle 50 -> IDLE at cycle 51 with GNT=0 and no DONE. With the macro defined, ABORTED=0001 pulses and ABORT_STICKY=1.
- RSTN low asynchronously mid-RUN while REQ1 is pending -> all outputs 0 immediately. After release, requester 0 wins if requesting; otherwise requester 1 is granted.
- DLY1 changed during RUN -> no effect on the current timing; the new value is used only at the next LOAD.
